// File: rtl/id_ex_pkg.sv
// Shared types and width constants for the ID/EX pipeline register.
// The ID_EX_STATS_EN macro adds a stall counter to id_ex_stage.
package id_ex_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned RA_W_DEF = 5;
   localparam int unsigned CTRL_W   = 10;
   localparam int unsigned STALL_W  = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [2:0] funct3;
      logic [2:0] alu_control;
      logic [1:0] mem_ctrl;
      logic       reg_write;
      logic       alu_src;
   } id_ex_ctrl_t;

   // Layout at default widths; id_ex_stage packs in the same order for any XLEN/RA_W.
   typedef struct packed {
      logic [XLEN_DEF-1:0] rd1;
      logic [XLEN_DEF-1:0] rd2;
      logic [XLEN_DEF-1:0] imm;
      logic [RA_W_DEF-1:0] a3;
      id_ex_ctrl_t         ctrl;
   } id_ex_payload_t;

   function automatic int unsigned payload_w(input int unsigned xlen, input int unsigned ra_w);
      return 3 * xlen + ra_w + CTRL_W;
   endfunction

endpackage

// File: rtl/id_ex_stage_pipe_skid_buf.sv
// Two-entry skid buffer (main + skid) with registered in_ready and synchronous flush.
module pipe_skid_buf
   import id_ex_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state;
   logic [W-1:0] skid;
   logic         in_xfer;
   logic         out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         skid      <= '0;
      end else if (flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (out_xfer && in_xfer) begin
                  out_data <= in_data;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end else if (in_xfer) begin
                  skid     <= in_data;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain move is possible
               if (out_ready) begin
                  out_data <= skid;
                  in_ready <= 1'b1;
                  state    <= BUSY;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: packs decode fields into a skid buffer, bubbles read as NOPs.
// Optional ID_EX_STATS_EN adds a saturating stall_cnt output.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned RA_W = RA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     rd1_in,
   input  logic [XLEN-1:0]     rd2_in,
   input  logic [XLEN-1:0]     imm_in,
   input  logic [RA_W-1:0]     a3_in,
   input  logic [2:0]          funct3_in,
   input  logic [2:0]          alu_control_in,
   input  logic [1:0]          mem_ctrl_in,
   input  logic                reg_write_in,
   input  logic                alu_src_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     rd1_out,
   output logic [XLEN-1:0]     rd2_out,
   output logic [XLEN-1:0]     imm_out,
   output logic [RA_W-1:0]     a3_out,
   output logic [2:0]          funct3_out,
   output logic [2:0]          alu_control_out,
   output logic [1:0]          mem_ctrl_out,
`ifdef ID_EX_STATS_EN
   output logic [STALL_W-1:0]  stall_cnt,
`endif
   output logic                reg_write_out,
   output logic                alu_src_out
);

   localparam int unsigned PW = payload_w(XLEN, RA_W);

   id_ex_ctrl_t   ctrl_in;
   id_ex_ctrl_t   ctrl_out;
   logic [PW-1:0] in_data;
   logic [PW-1:0] out_data;

   always_comb begin
      ctrl_in             = '0;
      ctrl_in.funct3      = funct3_in;
      ctrl_in.alu_control = alu_control_in;
      ctrl_in.mem_ctrl    = mem_ctrl_in;
      ctrl_in.reg_write   = reg_write_in;
      ctrl_in.alu_src     = alu_src_in;
   end

   assign in_data = {rd1_in, rd2_in, imm_in, a3_in, ctrl_in};

   pipe_skid_buf #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   assign {rd1_out, rd2_out, imm_out, a3_out, ctrl_out} = out_data;

   assign funct3_out      = ctrl_out.funct3;
   assign alu_control_out = ctrl_out.alu_control;
   assign alu_src_out     = ctrl_out.alu_src;
   // Side-effecting controls are masked so a bubble cannot write regs or memory
   assign reg_write_out   = out_valid & ctrl_out.reg_write;
   assign mem_ctrl_out    = out_valid ? ctrl_out.mem_ctrl : 2'b00;

`ifdef ID_EX_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized queue model.
// Define ID_EX_STATS_EN to also exercise the stall counter.
module tb_id_ex_stage;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  a3;
      logic [2:0]  f3;
      logic [2:0]  alu;
      logic [1:0]  mem;
      logic        rw;
      logic        src;
   } pl_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] rd1_in = '0, rd2_in = '0, imm_in = '0;
   logic [4:0]  a3_in = '0;
   logic [2:0]  funct3_in = '0, alu_control_in = '0;
   logic [1:0]  mem_ctrl_in = '0;
   logic        reg_write_in = 1'b0, alu_src_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] rd1_out, rd2_out, imm_out;
   logic [4:0]  a3_out;
   logic [2:0]  funct3_out, alu_control_out;
   logic [1:0]  mem_ctrl_out;
   logic        reg_write_out, alu_src_out;
`ifdef ID_EX_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int  n_tests = 0;
   int  n_fail  = 0;
   pl_t q[$];

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .rd1_in          (rd1_in),
      .rd2_in          (rd2_in),
      .imm_in          (imm_in),
      .a3_in           (a3_in),
      .funct3_in       (funct3_in),
      .alu_control_in  (alu_control_in),
      .mem_ctrl_in     (mem_ctrl_in),
      .reg_write_in    (reg_write_in),
      .alu_src_in      (alu_src_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .rd1_out         (rd1_out),
      .rd2_out         (rd2_out),
      .imm_out         (imm_out),
      .a3_out          (a3_out),
      .funct3_out      (funct3_out),
      .alu_control_out (alu_control_out),
      .mem_ctrl_out    (mem_ctrl_out),
`ifdef ID_EX_STATS_EN
      .stall_cnt       (stall_cnt),
`endif
      .reg_write_out   (reg_write_out),
      .alu_src_out     (alu_src_out)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pl_t obs_pl();
      return {rd1_out, rd2_out, imm_out, a3_out, funct3_out, alu_control_out,
              mem_ctrl_out, reg_write_out, alu_src_out};
   endfunction

   function automatic pl_t rand_pl();
      pl_t p;
      p.rd1 = $urandom; p.rd2 = $urandom; p.imm = $urandom;
      p.a3  = 5'($urandom); p.f3 = 3'($urandom); p.alu = 3'($urandom);
      p.mem = 2'($urandom); p.rw = 1'($urandom); p.src = 1'($urandom);
      return p;
   endfunction

   task automatic drive(input pl_t p);
      rd1_in = p.rd1; rd2_in = p.rd2; imm_in = p.imm; a3_in = p.a3;
      funct3_in = p.f3; alu_control_in = p.alu; mem_ctrl_in = p.mem;
      reg_write_in = p.rw; alu_src_in = p.src;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      pl_t pa, pb, pc, p;
      bit  ix, ox;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_ovalid", out_valid, 1'b0);
      chk("rst_iready", in_ready, 1'b1);
      chk("rst_payload", obs_pl(), '0);
`ifdef ID_EX_STATS_EN
      chk("rst_stall", stall_cnt, 16'h0);
`endif
      tick();
      tick();

      // Streaming with out_ready held high
      rst = 1'b0;
      p = rand_pl(); p.rd1 = 32'h11; drive(p);
      in_valid = 1'b1; out_ready = 1'b1;
      chk("stream_pre_ovalid", out_valid, 1'b0);
      tick();
      chk("stream_c1_ovalid", out_valid, 1'b1);
      chk("stream_c1_rd1", rd1_out, 32'h11);
      for (int i = 0; i < 4; i++) begin
         p.rd1 = 32'h20 + 32'(i); drive(p);
         tick();
         chk("stream_ovalid", out_valid, 1'b1);
         chk("stream_iready", in_ready, 1'b1);
         chk("stream_rd1", rd1_out, 32'h20 + 32'(i));
      end

      // Backpressure: A, B fill the buffer, C waits
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      pa = rand_pl(); pa.imm = 32'h5;
      pb = rand_pl(); pb.imm = 32'h6;
      pc = rand_pl(); pc.imm = 32'h7;
      drive(pa); in_valid = 1'b1;
      tick();
      chk("bp_a_iready", in_ready, 1'b1);
      drive(pb);
      tick();
      chk("bp_b_iready", in_ready, 1'b0);
      chk("bp_head_a", obs_pl(), pa);
      drive(pc);
      tick();
      chk("bp_hold_iready", in_ready, 1'b0);
      chk("bp_hold_a", obs_pl(), pa);
      out_ready = 1'b1;
      tick();
      chk("bp_out_b", obs_pl(), pb);
      chk("bp_iready_back", in_ready, 1'b1);
      tick();
      chk("bp_out_c", obs_pl(), pc);
      in_valid = 1'b0;
      tick();
      chk("bp_empty_ovalid", out_valid, 1'b0);
      chk("bp_bubble_rw", reg_write_out, 1'b0);
      chk("bp_bubble_mem", mem_ctrl_out, 2'b00);
      chk("bp_bubble_imm_hold", imm_out, 32'h7);

      // Flush while FULL with a new input presented
      out_ready = 1'b0; in_valid = 1'b1;
      p = rand_pl(); p.rw = 1'b1; p.mem = 2'b11; drive(p);
      tick();
      tick();
      chk("fl_full_iready", in_ready, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl_ovalid", out_valid, 1'b0);
      chk("fl_iready", in_ready, 1'b1);
      chk("fl_rw", reg_write_out, 1'b0);
      chk("fl_mem", mem_ctrl_out, 2'b00);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("fl_no_emerge", out_valid, 1'b0);
      end

      // Asynchronous reset mid-cycle while FULL
      out_ready = 1'b0; in_valid = 1'b1; drive(rand_pl());
      tick();
      tick();
      in_valid = 1'b0;
      chk("ar_full_iready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ar_ovalid", out_valid, 1'b0);
      chk("ar_iready", in_ready, 1'b1);
      chk("ar_payload", obs_pl(), '0);
      tick();
      rst = 1'b0;

      // Randomized traffic against a queue model
      q.delete();
      for (int c = 0; c < 12000; c++) begin
         chk("rnd_ovalid", out_valid, q.size() > 0);
         chk("rnd_iready", in_ready, q.size() < 2);
         if (q.size() > 0) begin
            chk("rnd_head", obs_pl(), q[0]);
         end else begin
            chk("rnd_bubble", {reg_write_out, mem_ctrl_out}, 3'b000);
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         p = rand_pl(); drive(p);
         if (flush) begin
            q.delete();
         end else begin
            ox = out_ready && (q.size() > 0);
            ix = in_valid && (q.size() < 2);
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(p);
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;

`ifdef ID_EX_STATS_EN
      // Stall counter saturation
      rst = 1'b1;
      #1;
      rst = 1'b0;
      chk("st_clear", stall_cnt, 16'h0);
      out_ready = 1'b0; in_valid = 1'b1; drive(rand_pl());
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 70000; i++) tick();
      chk("st_sat", stall_cnt, 16'hFFFF);
      tick();
      chk("st_no_wrap", stall_cnt, 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
